// File: rtl/rom.sv
// 16-word x 16-bit constant lookup table with a registered output.
// One read per clock; reset clears the output register.
module rom (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  output logic [15:0] out
);

  logic [15:0] word;

  always_comb begin
    word = 16'h0000;
    unique case (addr)
      4'h0: word = 16'h5601;
      4'h1: word = 16'h3401;
      4'h2: word = 16'h1202;
      4'h3: word = 16'h7803;
      4'h4: word = 16'h0A04;
      4'h5: word = 16'hBC05;
      4'h6: word = 16'hDE06;
      4'h7: word = 16'hF007;
      4'h8: word = 16'h1108;
      4'h9: word = 16'h2209;
      4'hA: word = 16'h330A;
      4'hB: word = 16'h440B;
      4'hC: word = 16'h550C;
      4'hD: word = 16'h660D;
      4'hE: word = 16'h770E;
      4'hF: word = 16'h5401;
      default: word = 16'h0000;
    endcase
  end

  // Reset wins over the read; addr is ignored while rst is high.
  always_ff @(posedge clk) begin
    if (rst) out <= 16'h0000;
    else     out <= word;
  end

endmodule

// File: tb/tb_rom.sv
// Directed self-checking bench for the rom lookup table.
// Inputs change just after the rising edge; out is sampled 1 unit after it.
module tb_rom;

  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic [15:0] out;

  int n_cmp;
  int n_bad;

  logic [15:0] table_exp [16];

  rom dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    addr = 4'h5;
    tick();
    tick();
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected %h", out, 16'h0000);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out !== 16'hBC05) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", out, 16'hBC05);
    end
  endtask

  task automatic test_single_reads();
    logic [3:0]  a [3];
    logic [15:0] e [3];
    a[0] = 4'h0; e[0] = 16'h5601;
    a[1] = 4'h1; e[1] = 16'h3401;
    a[2] = 4'hF; e[2] = 16'h5401;
    for (int i = 0; i < 3; i++) begin
      addr = a[i];
      tick();
      #3;
      n_cmp++;
      if (out !== e[i]) begin
        n_bad++;
        $display("FAIL single_read addr=%h: got %h expected %h", a[i], out, e[i]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      n_cmp++;
      if (out !== table_exp[i]) begin
        n_bad++;
        $display("FAIL sweep addr=%0d: got %h expected %h", i, out, table_exp[i]);
      end
    end
  endtask

  task automatic test_latency_hold();
    addr = 4'h2;
    tick();
    n_cmp++;
    if (out !== 16'h1202) begin
      n_bad++;
      $display("FAIL hold_first: got %h expected %h", out, 16'h1202);
    end
    addr = 4'h3;
    #2;
    n_cmp++;
    if (out !== 16'h1202) begin
      n_bad++;
      $display("FAIL hold_midcycle: got %h expected %h", out, 16'h1202);
    end
    tick();
    n_cmp++;
    if (out !== 16'h7803) begin
      n_bad++;
      $display("FAIL hold_next: got %h expected %h", out, 16'h7803);
    end
  endtask

  task automatic test_reset_priority();
    addr = 4'h9;
    tick();
    addr = 4'hF;
    rst  = 1'b1;
    tick();
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_priority: got %h expected %h", out, 16'h0000);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out !== 16'h5401) begin
      n_bad++;
      $display("FAIL reset_priority_release: got %h expected %h", out, 16'h5401);
    end
  endtask

  task automatic test_wrap();
    addr = 4'hF;
    tick();
    n_cmp++;
    if (out !== 16'h5401) begin
      n_bad++;
      $display("FAIL wrap_f: got %h expected %h", out, 16'h5401);
    end
    addr = 4'h0;
    tick();
    n_cmp++;
    if (out !== 16'h5601) begin
      n_bad++;
      $display("FAIL wrap_0: got %h expected %h", out, 16'h5601);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [6];
    seq[0] = 4'h7; seq[1] = 4'h4; seq[2] = 4'hA;
    seq[3] = 4'h4; seq[4] = 4'hE; seq[5] = 4'h6;
    for (int i = 0; i < 6; i++) begin
      addr = seq[i];
      tick();
      n_cmp++;
      if (out !== table_exp[seq[i]]) begin
        n_bad++;
        $display("FAIL back_to_back addr=%h: got %h expected %h", seq[i], out, table_exp[seq[i]]);
      end
    end
  endtask

  initial begin
    table_exp[0]  = 16'h5601; table_exp[1]  = 16'h3401;
    table_exp[2]  = 16'h1202; table_exp[3]  = 16'h7803;
    table_exp[4]  = 16'h0A04; table_exp[5]  = 16'hBC05;
    table_exp[6]  = 16'hDE06; table_exp[7]  = 16'hF007;
    table_exp[8]  = 16'h1108; table_exp[9]  = 16'h2209;
    table_exp[10] = 16'h330A; table_exp[11] = 16'h440B;
    table_exp[12] = 16'h550C; table_exp[13] = 16'h660D;
    table_exp[14] = 16'h770E; table_exp[15] = 16'h5401;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    addr  = 4'h0;
    #2;
    test_reset();
    test_single_reads();
    test_sweep();
    test_latency_hold();
    test_reset_priority();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom.md
# rom

Synchronous 16-word × 16-bit read-only lookup table with a registered data output. It supplies fixed constant words (microcode/coefficient style) to downstream logic; the contents are hard-wired at synthesis and cannot be written at run time. One address is presented per cycle, and the addressed word appears on the output after the next rising clock edge.

## Interface
- Parameters: none. Width (16) and depth (16) are fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- addr  input  4  word address, 0x0–0xF.
- out  output  16  registered read data.

## Operation
- Fixed contents, addr → word:
  - 0x0 → 16'h5601
  - 0x1 → 16'h3401
  - 0x2 → 16'h1202
  - 0x3 → 16'h7803
  - 0x4 → 16'h0A04
  - 0x5 → 16'hBC05
  - 0x6 → 16'hDE06
  - 0x7 → 16'hF007
  - 0x8 → 16'h1108
  - 0x9 → 16'h2209
  - 0xA → 16'h330A
  - 0xB → 16'h440B
  - 0xC → 16'h550C
  - 0xD → 16'h660D
  - 0xE → 16'h770E
  - 0xF → 16'h5401
- Every rising edge with rst=0: out <= ROM[addr]. There is no enable; a read happens every cycle.
- Every rising edge with rst=1: out <= 16'h0000. Reset has priority over the read, and addr is ignored.
- The address decode is full: all 16 codes map to a defined word, and there is no default/X output.
- If addr contains X/Z, the output is don't-care. Synthesis must not infer latches.
- No write path and no internal state other than the out register.

## Timing
- Read latency is 1 cycle. An addr that is stable before rising edge N appears on out immediately after edge N and holds until edge N+1.
- out changes only on clock edges. Address changes between edges have no effect on out.
- Back-to-back reads at full rate, one new address per cycle, are supported with no bubbles.
- Reset value of out: 16'h0000, visible after the first rising edge with rst=1.
- Leaving reset: on the first edge with rst=0, out loads ROM[addr].
- Reset asserted mid-stream: out clears on that edge, and the pending read is discarded.
- Power-up, before any clock edge: out is undefined unless rst has been applied. Benches must apply rst or wait one edge before checking.

## Test plan
- Reset: hold rst=1 with addr=0x5 for 2 edges -> out=16'h0000; release rst -> next edge out=16'hBC05.
- Single reads on a 10-unit clock period, sampling mid-cycle after each edge:
  - addr=0x0 -> out=16'h5601
  - addr=0x1 -> out=16'h3401
  - addr=0xF -> out=16'h5401
- Full sweep: step addr 0x0..0xF, one per cycle -> out matches the table one cycle later, with no skipped or repeated words.
- Latency/hold: change addr mid-cycle from 0x2 to 0x3 -> out stays 16'h1202 until the next edge, then becomes 16'h7803.
- Reset priority: assert rst=1 on the same edge as addr=0xF -> out=16'h0000, not 16'h5401; deassert -> out=16'h5401 on the next edge.
- Wrap/boundary: addr 0xF then 0x0 on consecutive cycles -> out=16'h5401 then 16'h5601.
